multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32I-subset datapath.
// Outputs are decoded from the state register; mem_ready, zero and the instruction fields qualify a few of them.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [3:0] ALUControl,
   output logic [1:0] ResultSrc,
   output logic [2:0] ImmSrc,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALU_W   = 4;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
   localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
   localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
   localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
   localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(4);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADR    = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALUWB     = 4'd8,
      S_JAL       = 4'd9,
      S_BRANCH    = 4'd10,
      S_JALR_TGT  = 4'd11,
      S_JALR_LINK = 4'd12,
      S_TRAP      = 4'd13
   } state_t;

   state_t state_q, state_d;
   logic   alu_f3_ok;

   function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  alu_op = sub ? ALU_SUB : ALU_ADD;
         3'b100:  alu_op = ALU_XOR;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   endfunction

   assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);
   assign state     = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      ResultSrc  = 2'b00;
      ImmSrc     = 3'b000;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = mem_ready;
            IRWrite   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         // Branch/jump target is computed here from OldPC + imm and held in ALUOut.
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:    state_d = (alu_f3_ok && !(funct7b5 && funct3 != 3'b000)) ? S_EXEC_R : S_TRAP;
               OP_I:    state_d = alu_f3_ok ? S_EXEC_I : S_TRAP;
               OP_JAL:  state_d = S_JAL;
               OP_BR:   state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
               OP_JALR: state_d = S_JALR_TGT;
               default: state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MemRead = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWRITE: begin
            MemWrite   = 1'b1;
            AdrSrc     = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXEC_R: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_op(funct3, funct7b5);
            state_d    = S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_op(funct3, 1'b0);
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            instr_done = 1'b1;
            PCWrite    = funct3[0] ? ~zero : zero;
            state_d    = S_FETCH;
         end
         S_JALR_TGT: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            state_d   = S_JALR_LINK;
         end
         S_JALR_LINK: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = S_ALUWB;
         end
         S_TRAP: illegal = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected per-cycle output trace and compared cycle by cycle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [3:0] ALUControl, state;
   logic [2:0] ImmSrc;
   logic       instr_done, illegal;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .state(state), .instr_done(instr_done), .illegal(illegal)
   );

   typedef struct packed {
      logic       pcw, adr, memr, memw, irw, regw;
      logic [1:0] sa, sb;
      logic [3:0] alu;
      logic [1:0] rs;
      logic [2:0] imm;
      logic [3:0] st;
      logic       done, ill;
   } obs_t;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, mr, z;
      obs_t       o;
   } rec_t;

   obs_t  dut_o;
   assign dut_o = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
                   ALUControl, ResultSrc, ImmSrc, state, instr_done, illegal};

   rec_t  q[$];
   int    vectors = 0, miscompares = 0;
   int    exp_done = 0, done_seen = 0;
   bit    trapped;
   string tag;

   always @(posedge clk) if (instr_done === 1'b1) done_seen <= done_seen + 1;

   function automatic obs_t blank(input int unsigned st);
      obs_t c;
      c    = '0;
      c.st = 4'(st);
      return c;
   endfunction

   function automatic obs_t fetch_o(input logic mr);
      obs_t c;
      c = blank(0);
      c.memr = 1'b1; c.sb = 2'd2; c.rs = 2'd2; c.pcw = mr; c.irw = mr;
      return c;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // ALU code the datapath must see: add/sub=0/1, and=2, or=3, xor=4.
   function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
      case (f3)
         3'd0:    return sub ? 4'd1 : 4'd0;
         3'd4:    return 4'd4;
         3'd6:    return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   // Expand one instruction into its expected cycle trace.
   task automatic gen(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic z, input int fst, input int mst);
      obs_t c;
      bit ld, stw, r, i, br, jal, jalr, f3ok, legal;
      ld = (opc == 7'b0000011); stw = (opc == 7'b0100011);
      r  = (opc == 7'b0110011); i   = (opc == 7'b0010011);
      br = (opc == 7'b1100011); jal = (opc == 7'b1101111); jalr = (opc == 7'b1100111);
      f3ok  = (f3 == 0) || (f3 == 4) || (f3 == 6) || (f3 == 7);
      legal = ld || stw || jal || jalr || (i && f3ok) || (r && f3ok && !(f7 && f3 != 0)) ||
              (br && f3 <= 1);
      for (int k = 0; k < fst; k++) q.push_back('{opc, f3, f7, 1'b0, z, fetch_o(1'b0)});
      q.push_back('{opc, f3, f7, 1'b1, z, fetch_o(1'b1)});
      c = blank(1); c.sa = 2'd1; c.sb = 2'd1; c.imm = jal ? 3'd3 : 3'd2;
      q.push_back('{opc, f3, f7, rnd(), z, c});
      trapped = !legal;
      if (!legal) begin
         for (int k = 0; k < 10; k++) begin
            c = blank(13); c.ill = 1'b1;
            q.push_back('{opc, f3, f7, rnd(), z, c});
         end
         return;
      end
      if (ld || stw) begin
         c = blank(2); c.sa = 2'd2; c.sb = 2'd1; c.imm = stw ? 3'd1 : 3'd0;
         q.push_back('{opc, f3, f7, rnd(), z, c});
         c = blank(ld ? 3 : 5); c.adr = 1'b1; c.memr = ld; c.memw = stw;
         for (int k = 0; k < mst; k++) q.push_back('{opc, f3, f7, 1'b0, z, c});
         c.done = stw;
         q.push_back('{opc, f3, f7, 1'b1, z, c});
         if (ld) begin
            c = blank(4); c.rs = 2'd1; c.regw = 1'b1; c.done = 1'b1;
            q.push_back('{opc, f3, f7, rnd(), z, c});
         end
         return;
      end
      if (br) begin
         c = blank(10); c.sa = 2'd2; c.alu = 4'd1; c.done = 1'b1;
         c.pcw = f3[0] ? !z : z;
         q.push_back('{opc, f3, f7, rnd(), z, c});
         return;
      end
      if (r || i) begin
         c = blank(r ? 6 : 7); c.sa = 2'd2; c.sb = r ? 2'd0 : 2'd1;
         c.alu = alu_of(f3, r && f7);
         q.push_back('{opc, f3, f7, rnd(), z, c});
      end else if (jal) begin
         c = blank(9); c.sa = 2'd1; c.sb = 2'd2; c.pcw = 1'b1;
         q.push_back('{opc, f3, f7, rnd(), z, c});
      end else begin
         c = blank(11); c.sa = 2'd2; c.sb = 2'd1; c.rs = 2'd2; c.pcw = 1'b1;
         q.push_back('{opc, f3, f7, rnd(), z, c});
         c = blank(12); c.sa = 2'd1; c.sb = 2'd2;
         q.push_back('{opc, f3, f7, rnd(), z, c});
      end
      c = blank(8); c.regw = 1'b1; c.done = 1'b1;
      q.push_back('{opc, f3, f7, rnd(), z, c});
   endtask

   task automatic check(input obs_t e);
      vectors++;
      assert (dut_o === e) else begin
         miscompares++;
         $error("FAIL %s state=%0d: observed %h expected %h", tag, e.st, dut_o, e);
      end
   endtask

   // Drive up to n queued cycles; entered at least 2 time units before a rising edge.
   task automatic apply(input int n);
      rec_t e;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         e = q.pop_front();
         op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.mr; zero = e.z;
         #2;
         check(e.o);
         exp_done += int'(e.o.done);
         @(posedge clk);
         #1;
      end
   endtask

   // Asynchronous reset pulse mid-cycle; FETCH outputs must appear before any edge.
   task automatic do_reset(input logic mr);
      mem_ready = mr;
      rst_n = 1'b0;
      #1;
      tag = "reset";
      check(fetch_o(mr));
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
   endtask

   initial begin
      rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      #3;
      tag = "reset_mr1"; check(fetch_o(1'b1));
      mem_ready = 1'b0; #1;
      tag = "reset_mr0"; check(fetch_o(1'b0));
      @(negedge clk);
      rst_n = 1'b1;

      tag = "add";  gen(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0); apply(99);
      tag = "lw";   gen(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 2); apply(99);
      tag = "bne1"; gen(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0); apply(99);
      tag = "bne0"; gen(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0); apply(99);
      tag = "jalr"; gen(7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0); apply(99);
      tag = "jal";  gen(7'b1101111, 3'd0, 1'b0, 1'b0, 1, 0); apply(99);
      tag = "sw";   gen(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1); apply(99);
      tag = "sub";  gen(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0); apply(99);
      tag = "addi7"; gen(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0); apply(99);
      tag = "trap"; gen(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0); apply(99);
      do_reset(1'b1);
      tag = "sw_abort"; gen(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 5); apply(4);
      do_reset(1'b0);
      tag = "post_abort"; gen(7'b0110011, 3'd4, 1'b0, 1'b0, 0, 0); apply(99);

      for (int n = 0; n < 200; n++) begin
         logic [6:0] opc;
         logic [2:0] f3;
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0:       opc = 7'b0000011;
            1:       opc = 7'b0100011;
            2, 3:    opc = 7'b0110011;
            4, 5:    opc = 7'b0010011;
            6:       opc = 7'b1100011;
            7:       opc = 7'b1101111;
            8:       opc = 7'b1100111;
            default: opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'b0110011;
         endcase
         if (opc == 7'b1100011 && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1));
         tag = "rand";
         gen(opc, f3, rnd(), rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
         apply(99);
         if (trapped) do_reset(rnd());
      end

      tag = "done_count";
      vectors++;
      assert (done_seen === exp_done) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, done_seen, exp_done);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
